// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues instruction reads at pc_value and queues {instr, pc} pairs for decode
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   pc_value / pc_advance      current fetch address in; pulse when that address is accepted
//   flush                      drop every buffered and in-flight fetch this cycle
//   mem_req_valid/ready/addr   read request channel to instruction memory
//   mem_resp_valid/data        in-order read responses, latency >= 1
//   instr_valid/ready          head-of-queue handshake to decode
//   instr_data/instr_pc        head instruction and the address it came from (0 when empty)
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_advance,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [ADDR_W-1:0] a_mem  [DEPTH];
    logic [PW-1:0] q_wp, q_rp, a_wp, a_rp;
    // outstanding counts live requests only; discard_cnt counts in-flight requests
    // orphaned by a flush. Both occupy credit until their response returns.
    logic [CW-1:0] q_count, outstanding, discard_cnt;
    logic [CW:0] in_use;
    logic accept, resp_keep, resp_live, resp_drain, deq;
    assign in_use        = {1'b0, q_count} + {1'b0, outstanding} + {1'b0, discard_cnt};
    assign mem_req_valid = !reset && !flush && (in_use < LIMIT);
    assign mem_addr      = mem_req_valid ? pc_value : '0;
    assign accept        = mem_req_valid && mem_req_ready;
    assign pc_advance    = accept;
    // responses retire discards first since they return in request order
    assign resp_drain    = mem_resp_valid && (discard_cnt != '0);
    assign resp_live     = mem_resp_valid && (discard_cnt == '0);
    assign resp_keep     = resp_live && !flush;
    assign instr_valid   = q_count != '0;
    assign deq           = instr_valid && instr_ready && !flush;
    assign instr_data    = instr_valid ? q_data[q_rp] : '0;
    assign instr_pc      = instr_valid ? q_pc[q_rp] : '0;
    always_ff @(posedge clk) begin
        if (accept) a_mem[a_wp] <= pc_value;
        if (resp_keep) begin
            q_data[q_wp] <= mem_resp_data;
            q_pc[q_wp]   <= a_mem[a_rp];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wp        <= '0;
            q_rp        <= '0;
            a_wp        <= '0;
            a_rp        <= '0;
            q_count     <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
        end else if (flush) begin
            q_wp        <= '0;
            q_rp        <= '0;
            a_wp        <= '0;
            a_rp        <= '0;
            q_count     <= '0;
            // every live request becomes a discard; a response arriving now is dropped too
            outstanding <= '0;
            discard_cnt <= discard_cnt + outstanding - CW'(mem_resp_valid);
        end else begin
            if (accept) a_wp <= a_wp + 1'b1;
            if (resp_keep) begin
                q_wp <= q_wp + 1'b1;
                a_rp <= a_rp + 1'b1;
            end
            if (deq) q_rp <= q_rp + 1'b1;
            q_count     <= q_count + CW'(resp_keep) - CW'(deq);
            outstanding <= outstanding + CW'(accept) - CW'(resp_live);
            discard_cnt <= discard_cnt - CW'(resp_drain);
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized memory/decode environment with a transaction-level reference model
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          epoch;
        int          due;
    } req_t;
    logic        clk = 0;
    logic        reset = 1;
    logic [15:0] pc_value = 16'h0010;
    logic        pc_advance;
    logic        flush = 0;
    logic        mem_req_valid;
    logic        mem_req_ready = 0;
    logic [15:0] mem_addr;
    logic        mem_resp_valid = 0;
    logic [15:0] mem_resp_data = 0;
    logic        instr_valid;
    logic        instr_ready = 0;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    req_t        pend[$];
    req_t        exp_q[$];
    int          epoch = 0;
    int          cyc = 0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    logic [15:0] redirect = 16'h0200;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_value(pc_value), .pc_advance(pc_advance),
        .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory returns responses in order after a per-request latency; a response is
    // delivered to decode only if no flush happened between its request and its return.
    task automatic tick(input int p_rdy, input int p_irdy, input int p_fl,
                        input int lat_lo, input int lat_hi);
        logic ev, acc, deq, rv, fl;
        req_t e;
        mem_req_ready  = int'($urandom_range(99)) < p_rdy;
        instr_ready    = int'($urandom_range(99)) < p_irdy;
        flush          = int'($urandom_range(99)) < p_fl;
        mem_resp_valid = pend.size() > 0 && pend[0].due <= cyc;
        mem_resp_data  = mem_resp_valid ? pend[0].data : 16'h0;
        #1;
        ev = !flush && (exp_q.size() + pend.size() < DEPTH);
        chk("req_valid", 32'(mem_req_valid), 32'(ev));
        chk("mem_addr", 32'(mem_addr), ev ? 32'(pc_value) : 32'h0);
        chk("pc_advance", 32'(pc_advance), 32'(ev && mem_req_ready));
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
        chk("instr_data", 32'(instr_data), exp_q.size() > 0 ? 32'(exp_q[0].data) : 32'h0);
        chk("instr_pc", 32'(instr_pc), exp_q.size() > 0 ? 32'(exp_q[0].addr) : 32'h0);
        acc = ev && mem_req_ready;
        deq = exp_q.size() > 0 && instr_ready && !flush;
        rv  = mem_resp_valid;
        fl  = flush;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (deq) void'(exp_q.pop_front());
        if (rv) begin
            e = pend.pop_front();
            if (!fl && e.epoch == epoch) exp_q.push_back(e);
        end
        if (fl) begin
            exp_q.delete();
            epoch++;
            pc_value = redirect;
            redirect = 16'($urandom);
        end
        if (acc) begin
            e.addr  = pc_value;
            e.data  = 16'($urandom);
            e.epoch = epoch;
            e.due   = cyc + int'($urandom_range(lat_hi, lat_lo)) - 1;
            pend.push_back(e);
            pc_value = pc_value + 16'h1;
        end
    endtask

    task automatic mid_reset();
        #2 reset = 1;
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_pc_advance", 32'(pc_advance), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr_data", 32'(instr_data), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        pend.delete();
        exp_q.delete();
        mem_resp_valid = 0;
        mem_resp_data  = 0;
        flush          = 0;
        @(negedge clk);
        reset    = 0;
        pc_value = 16'h0040;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_req_valid", 32'(mem_req_valid), 32'h0);
        chk("reset_instr_valid", 32'(instr_valid), 32'h0);
        chk("reset_instr_pc", 32'(instr_pc), 32'h0);
        reset = 0;
        // single fetch and streaming at latency 1
        repeat (20) tick(100, 100, 0, 1, 1);
        // decode stalled: credit runs out at DEPTH, then drains in order
        repeat (10) tick(100, 0, 0, 1, 1);
        repeat (10) tick(100, 100, 0, 1, 1);
        // memory back-pressure: request held, address stable
        repeat (3) tick(0, 100, 0, 1, 1);
        repeat (3) tick(100, 100, 0, 1, 1);
        // two requests in flight at latency 3, then flush with redirect to 0x0100
        repeat (6) tick(0, 100, 0, 1, 1);
        repeat (2) tick(100, 0, 0, 3, 3);
        redirect = 16'h0100;
        tick(0, 0, 100, 3, 3);
        repeat (12) tick(100, 100, 0, 3, 3);
        // fill the queue then run mixed push/pop traffic
        repeat (8) tick(100, 0, 0, 1, 1);
        repeat (20) tick(100, 50, 0, 1, 2);
        // randomized traffic with flushes
        for (int k = 0; k < 40; k++) begin
            int pr, pi, pf, lh;
            pr = int'($urandom_range(100, 20));
            pi = int'($urandom_range(100, 10));
            pf = int'($urandom_range(8));
            lh = int'($urandom_range(5, 1));
            repeat (50) tick(pr, pi, pf, 1, lh);
        end
        // asynchronous reset mid-stream, then resume
        repeat (5) tick(100, 30, 0, 1, 3);
        mid_reset();
        repeat (30) tick(80, 70, 3, 1, 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
